// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for a multicycle RV32I datapath that
// shares one instruction/data memory port. It decodes op/funct3/funct7b5,
// issues per-state selects and strobes, and stalls on a req/ready handshake.
module multicycle_controller #(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       irq_clear,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic [3:0] alu_funct;
    logic   mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;

    // Next-state selection and sticky illegal flag (set on entry to TRAP).
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
            S_TRAP:     if (!RESET_TRAP && irq_clear) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        if (state_d == S_TRAP) illegal_d = 1'b1;
    end

    // State and illegal-flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // funct3/funct7b5 to ALU operation; sub only for R-type with funct7b5 set.
    always_comb begin
        alu_funct = ALU_ADD;
        case (funct3)
            3'b000:  alu_funct = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_funct = ALU_SLL;
            3'b010:  alu_funct = ALU_SLT;
            3'b011:  alu_funct = ALU_SLTU;
            3'b100:  alu_funct = ALU_XOR;
            3'b101:  alu_funct = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_funct = ALU_OR;
            default: alu_funct = ALU_AND;
        endcase
    end

    // Per-state datapath controls; only mem_ready, Zero and funct3 gate strobes.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 2'b00;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_STORE:  ImmSrc = 2'b01;
                    OP_BRANCH: ImmSrc = 2'b10;
                    OP_JAL:    ImmSrc = 2'b11;
                    default:   ImmSrc = 2'b00;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                AdrSrc      = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                ImmSrc     = 2'b10;
                pc_write_s = Zero ^ funct3[0];
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ImmSrc     = 2'b11;
                pc_write_s = 1'b1;
            end
            S_LUI: begin
                ResultSrc   = 2'b11;
                reg_write_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are held off combinationally for the whole time reset is low.
    assign mem_req  = mem_req_s   & reset_n;
    assign MemWrite = mem_write_s & reset_n;
    assign IRWrite  = ir_write_s  & reset_n;
    assign PCWrite  = pc_write_s  & reset_n;
    assign RegWrite = reg_write_s & reset_n;
    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller with hand-computed expectations.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       irq_clear = 1'b0;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl, state;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    multicycle_controller #(.RESET_TRAP(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .irq_clear(irq_clear), .op(op),
        .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ALU vectors: op, funct3, funct7b5, expected exec state, expected ALUControl
    typedef struct { logic [6:0] op; logic [2:0] f3; logic f7; logic [3:0] st; logic [3:0] alu; } alu_vec_t;
    alu_vec_t alu_tab[5] = '{
        '{7'b0110011, 3'b000, 1'b1, 4'd6, 4'b0001},
        '{7'b0010011, 3'b000, 1'b1, 4'd7, 4'b0000},
        '{7'b0010011, 3'b101, 1'b1, 4'd7, 4'b1000},
        '{7'b0110011, 3'b101, 1'b0, 4'd6, 4'b0111},
        '{7'b0110011, 3'b011, 1'b0, 4'd6, 4'b1001}
    };

    // Branch vectors: funct3, Zero, expected PCWrite
    typedef struct { logic [2:0] f3; logic z; logic pcw; } br_vec_t;
    br_vec_t br_tab[4] = '{
        '{3'b000, 1'b1, 1'b1},
        '{3'b000, 1'b0, 1'b0},
        '{3'b001, 1'b0, 1'b1},
        '{3'b001, 1'b1, 1'b0}
    };

    logic [3:0] lw_st[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic       lw_rw[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset held across clock edges
        tick();
        tick();
        check("rst_state", state, 4'd0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_irwrite", IRWrite, 1'b0);
        check("rst_pcwrite", PCWrite, 1'b0);
        reset_n = 1'b1;
        #1;

        // lw, zero-wait: 0,1,2,3,4 then back to 0
        op = 7'b0000011;
        check("lw_fetch_irw", IRWrite, 1'b1);
        check("lw_fetch_req", mem_req, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("lw_state", state, lw_st[i]);
            check("lw_regwrite", RegWrite, lw_rw[i]);
            if (i == 4) check("lw_resultsrc", ResultSrc, 2'b01);
            tick();
        end
        check("lw_back_fetch", state, 4'd0);

        // sw with three stall cycles in MEMWRITE
        op = 7'b0100011;
        tick();
        check("sw_decode_imm", ImmSrc, 2'b01);
        tick();
        check("sw_memadr", state, 4'd2);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("sw_state", state, 4'd5);
            check("sw_mem_req", mem_req, 1'b1);
            check("sw_memwrite", MemWrite, 1'b1);
            check("sw_regwrite", RegWrite, 1'b0);
            tick();
        end
        check("sw_back_fetch", state, 4'd0);

        // ALU decode
        foreach (alu_tab[k]) begin
            op = alu_tab[k].op; funct3 = alu_tab[k].f3; funct7b5 = alu_tab[k].f7;
            tick();
            tick();
            check("alu_exec_state", state, alu_tab[k].st);
            check("alu_control", ALUControl, alu_tab[k].alu);
            tick();
            check("alu_wb_state", state, 4'd8);
            check("alu_wb_regwrite", RegWrite, 1'b1);
            tick();
            check("alu_fetch", state, 4'd0);
        end

        // beq / bne
        op = 7'b1100011;
        foreach (br_tab[k]) begin
            funct3 = br_tab[k].f3; Zero = br_tab[k].z;
            tick();
            tick();
            check("br_state", state, 4'd9);
            check("br_pcwrite", PCWrite, br_tab[k].pcw);
            check("br_alu_sub", ALUControl, 4'b0001);
            tick();
            check("br_fetch", state, 4'd0);
        end
        Zero = 1'b0; funct3 = 3'b000;

        // jal: 0,1,10,8,0
        op = 7'b1101111;
        tick();
        check("jal_decode_imm", ImmSrc, 2'b11);
        tick();
        check("jal_state", state, 4'd10);
        check("jal_pcwrite", PCWrite, 1'b1);
        tick();
        check("jal_wb", state, 4'd8);
        tick();
        check("jal_fetch", state, 4'd0);

        // lui: 0,1,11,0
        op = 7'b0110111;
        tick();
        tick();
        check("lui_state", state, 4'd11);
        check("lui_resultsrc", ResultSrc, 2'b11);
        check("lui_regwrite", RegWrite, 1'b1);
        tick();
        check("lui_fetch", state, 4'd0);
        check("lui_illegal", illegal, 1'b0);

        // Illegal opcode traps and stays put
        op = 7'b1111111;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("trap_state", state, 4'd12);
            check("trap_mem_req", mem_req, 1'b0);
            check("trap_illegal", illegal, 1'b1);
            tick();
        end
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("trap_clr_state", state, 4'd0);
        check("trap_clr_illegal", illegal, 1'b1);

        // Unsupported branch funct3 also traps
        op = 7'b1100011; funct3 = 3'b010;
        tick();
        tick();
        check("br_bad_f3_trap", state, 4'd12);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("br_bad_f3_clr", state, 4'd0);
        funct3 = 3'b000;

        // Reset asserted mid-access in MEMREAD
        op = 7'b0000011;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("mid_memread", state, 4'd3);
        check("mid_req_before", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", state, 4'd0);
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rst_illegal", illegal, 1'b0);
        mem_ready = 1'b1;
        reset_n = 1'b1;
        #1;
        check("post_rst_req", mem_req, 1'b1);
        tick();
        check("post_rst_decode", state, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
